// File: rtl/work_loader.sv
// Header assembler: pops HDR_WORDS words from the read-master user FIFO,
// optionally byte-swaps them, and offers the 640-bit header over valid/ready.
module work_loader #(
  parameter int HDR_WORDS  = 20,
  parameter bit SWAP_BYTES = 1'b1,
  localparam int CW = $clog2(HDR_WORDS)
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    load_go,
  input  logic                    abort,
  input  logic                    read_user_data_available,
  input  logic [31:0]             read_user_buffer_output_data,
  output logic                    read_user_read_buffer,
  output logic [HDR_WORDS*32-1:0] header,
  output logic [31:0]             nonce_base,
  output logic                    work_valid,
  input  logic                    work_ready,
  output logic                    busy,
  output logic [CW-1:0]           words_loaded,
  output logic                    overrun
);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

  localparam logic [CW-1:0] LAST = CW'(HDR_WORDS - 1);

  state_t                     state, state_nxt;
  logic [HDR_WORDS-1:0][31:0] hdr;
  logic [CW-1:0]              cnt;
  logic                       capture;
  logic                       start;
  logic [31:0]                word_in;

  always_comb begin
    if (SWAP_BYTES)
      word_in = {read_user_buffer_output_data[7:0],
                 read_user_buffer_output_data[15:8],
                 read_user_buffer_output_data[23:16],
                 read_user_buffer_output_data[31:24]};
    else
      word_in = read_user_buffer_output_data;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // abort dominates: it also suppresses the pop in its own cycle.
  always_comb begin
    state_nxt             = state;
    read_user_read_buffer = 1'b0;
    capture               = 1'b0;
    start                 = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (load_go) begin
          state_nxt = LOAD;
          start     = 1'b1;
        end
        LOAD: if (read_user_data_available) begin
          read_user_read_buffer = 1'b1;
          capture               = 1'b1;
          if (cnt == LAST) state_nxt = HOLD;
        end
        HOLD: if (work_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hdr     <= '0;
      cnt     <= '0;
      overrun <= 1'b0;
    end else if (abort) begin
      hdr     <= '0;
      cnt     <= '0;
      overrun <= 1'b0;
    end else begin
      if (start) begin
        hdr <= '0;
        cnt <= '0;
      end
      if (capture) begin
        hdr[LAST - cnt] <= word_in;
        cnt             <= cnt + CW'(1);
      end
      if (load_go && state != IDLE) overrun <= 1'b1;
    end
  end

  assign header       = hdr;
  assign nonce_base   = hdr[0];
  assign work_valid   = (state == HOLD);
  assign busy         = (state != IDLE);
  assign words_loaded = cnt;

endmodule

// File: tb/tb_work_loader.sv
// Self-checking bench for work_loader: FIFO model plus header scoreboard.
module tb_work_loader;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         load_go, abort, work_ready;
  logic         fifo_avail;
  logic [31:0]  fifo_data;
  logic         pop;
  logic [639:0] header;
  logic [31:0]  nonce_base;
  logic         work_valid, busy, overrun;
  logic [4:0]   words_loaded;

  logic         ns_load_go, ns_abort, ns_ready, ns_avail, ns_pop;
  logic         ns_valid, ns_busy, ns_overrun;
  logic [31:0]  ns_data, ns_nonce, ns_idx;
  logic [639:0] ns_header;
  logic [4:0]   ns_words;

  logic [31:0]  fifo_mem [256];
  int           fifo_wr;
  int           fifo_ptr;
  int           pop_cnt;
  logic         gap;

  logic [639:0] sb [$];
  int           n_checks = 0;
  int           n_fail   = 0;

  always #5 clk = ~clk;

  work_loader #(.HDR_WORDS(20), .SWAP_BYTES(1'b1)) u_dut (
    .clk                          (clk),
    .n_rst                        (n_rst),
    .load_go                      (load_go),
    .abort                        (abort),
    .read_user_data_available     (fifo_avail),
    .read_user_buffer_output_data (fifo_data),
    .read_user_read_buffer        (pop),
    .header                       (header),
    .nonce_base                   (nonce_base),
    .work_valid                   (work_valid),
    .work_ready                   (work_ready),
    .busy                         (busy),
    .words_loaded                 (words_loaded),
    .overrun                      (overrun)
  );

  work_loader #(.HDR_WORDS(20), .SWAP_BYTES(1'b0)) u_noswap (
    .clk                          (clk),
    .n_rst                        (n_rst),
    .load_go                      (ns_load_go),
    .abort                        (ns_abort),
    .read_user_data_available     (ns_avail),
    .read_user_buffer_output_data (ns_data),
    .read_user_read_buffer        (ns_pop),
    .header                       (ns_header),
    .nonce_base                   (ns_nonce),
    .work_valid                   (ns_valid),
    .work_ready                   (ns_ready),
    .busy                         (ns_busy),
    .words_loaded                 (ns_words),
    .overrun                      (ns_overrun)
  );

  // Show-ahead FIFO model for the main instance.
  assign fifo_data  = fifo_mem[fifo_ptr[7:0]];
  assign fifo_avail = (fifo_ptr < fifo_wr) && !gap;

  initial begin
    fifo_ptr = 0;
    pop_cnt  = 0;
  end

  always @(posedge clk) begin
    if (pop) begin
      fifo_ptr <= fifo_ptr + 1;
      pop_cnt  <= pop_cnt + 1;
    end
  end

  // Unswapped instance: word 0 is 0xAABBCCDD, word k (k>0) is k.
  assign ns_data  = (ns_idx == 32'd0) ? 32'hAABBCCDD : ns_idx;
  assign ns_avail = 1'b1;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst)      ns_idx <= 32'd0;
    else if (ns_pop) ns_idx <= ns_idx + 32'd1;
  end

  task automatic check(input string tag, input logic [639:0] got, input logic [639:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [639:0] exp_hdr(input int base);
    logic [639:0] r;
    logic [31:0]  w;
    r = '0;
    for (int i = 0; i < 20; i++) begin
      w = fifo_mem[base + i];
      r[639 - 32*i -: 32] = {w[7:0], w[15:8], w[23:16], w[31:24]};
    end
    return r;
  endfunction

  task automatic append(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_mem[fifo_wr] = first + 32'(i);
      fifo_wr++;
    end
  endtask

  // Returns at the negedge following the load_go edge.
  task automatic start_load();
    @(negedge clk);
    sb.push_back(exp_hdr(fifo_ptr));
    load_go = 1'b1;
    @(negedge clk);
    load_go = 1'b0;
  endtask

  task automatic wait_valid(input int cyc0, output int cyc);
    logic [639:0] e;
    cyc = cyc0;
    while (!work_valid && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("valid_timeout", {639'd0, work_valid}, 640'd1);
    if (sb.size() == 0) begin
      check("sb_empty", 640'd1, 640'd0);
    end else begin
      e = sb.pop_front();
      check("sb_header", header, e);
    end
  endtask

  task automatic accept();
    @(negedge clk);
    work_ready = 1'b1;
    @(negedge clk);
    work_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, p0, b;
    logic [639:0] prev;
    n_rst = 1'b0; load_go = 1'b0; abort = 1'b0; work_ready = 1'b0; gap = 1'b0;
    ns_load_go = 1'b0; ns_abort = 1'b0; ns_ready = 1'b0;
    fifo_wr = 0;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    check("rst_busy",    {639'd0, busy},       640'd0);
    check("rst_valid",   {639'd0, work_valid}, 640'd0);
    check("rst_pop",     {639'd0, pop},        640'd0);
    check("rst_header",  header,               640'd0);
    check("rst_nonce",   {608'd0, nonce_base}, 640'd0);
    check("rst_words",   {635'd0, words_loaded}, 640'd0);
    check("rst_overrun", {639'd0, overrun},    640'd0);

    // Continuous stream, swapped.
    append(32'd1, 20);
    p0 = pop_cnt;
    start_load();
    check("busy_after_go", {639'd0, busy}, 640'd1);
    wait_valid(0, cyc);
    check("valid_latency", 640'(cyc), 640'd20);
    check("pops_20", 640'(pop_cnt - p0), 640'd20);
    check("word0_swapped", {608'd0, header[639:608]}, 640'h01000000);
    check("nonce_swapped", {608'd0, nonce_base}, 640'h14000000);
    prev = header;
    accept();
    check("idle_after_acc", {639'd0, busy}, 640'd0);
    check("valid_drop", {639'd0, work_valid}, 640'd0);
    check("words_held", {635'd0, words_loaded}, 640'd20);

    // Same stream with a 3-cycle gap after word 7.
    append(32'd1, 20);
    p0 = pop_cnt;
    start_load();
    cyc = 0;
    while (pop_cnt - p0 < 7 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    gap = 1'b1;
    repeat (3) begin
      @(negedge clk);
      cyc++;
    end
    check("gap_no_pop", 640'(pop_cnt - p0), 640'd7);
    gap = 1'b0;
    wait_valid(cyc, cyc);
    check("gap_latency", 640'(cyc), 640'd23);
    check("gap_same_hdr", header, prev);

    // Hold with work_ready low and a non-empty FIFO.
    append(32'h100, 20);
    p0 = pop_cnt;
    repeat (50) @(negedge clk);
    check("hold_valid", {639'd0, work_valid}, 640'd1);
    check("hold_header", header, prev);
    check("hold_no_pop", 640'(pop_cnt - p0), 640'd0);
    accept();

    // Abort after 10 words.
    p0 = pop_cnt;
    b = fifo_ptr;
    start_load();
    cyc = 0;
    while (pop_cnt - p0 < 10 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_words10", {635'd0, words_loaded}, 640'd10);
    abort = 1'b1;
    #1;
    check("abort_no_pop", {639'd0, pop}, 640'd0);
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", {639'd0, busy}, 640'd0);
    check("abort_words0", {635'd0, words_loaded}, 640'd0);
    check("abort_header0", header, 640'd0);
    check("abort_pops", 640'(pop_cnt - p0), 640'd10);
    void'(sb.pop_front());
    check("abort_ptr", 640'(fifo_ptr - b), 640'd10);
    append(32'h200, 10);
    start_load();
    wait_valid(0, cyc);
    check("reload_word0", {608'd0, header[639:608]}, 640'h0a010000);
    accept();

    // load_go during LOAD, back-to-back, and abort+load_go.
    append(32'h300, 20);
    start_load();
    repeat (4) @(negedge clk);
    load_go = 1'b1;
    @(negedge clk);
    load_go = 1'b0;
    check("overrun_set", {639'd0, overrun}, 640'd1);
    wait_valid(5, cyc);
    check("overrun_latency", 640'(cyc), 640'd20);
    @(negedge clk);
    work_ready = 1'b1;
    load_go    = 1'b1;
    @(negedge clk);
    work_ready = 1'b0;
    load_go    = 1'b0;
    check("b2b_idle", {639'd0, busy}, 640'd0);
    check("b2b_overrun", {639'd0, overrun}, 640'd1);
    abort   = 1'b1;
    load_go = 1'b1;
    @(negedge clk);
    abort   = 1'b0;
    load_go = 1'b0;
    check("abgo_idle", {639'd0, busy}, 640'd0);
    check("abgo_overrun", {639'd0, overrun}, 640'd0);

    // Asynchronous reset mid-LOAD.
    append(32'h400, 20);
    start_load();
    repeat (5) @(negedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    check("arst_busy",    {639'd0, busy},       640'd0);
    check("arst_valid",   {639'd0, work_valid}, 640'd0);
    check("arst_pop",     {639'd0, pop},        640'd0);
    check("arst_header",  header,               640'd0);
    check("arst_nonce",   {608'd0, nonce_base}, 640'd0);
    check("arst_words",   {635'd0, words_loaded}, 640'd0);
    void'(sb.pop_front());
    @(negedge clk);
    n_rst = 1'b1;

    // Unswapped instance.
    @(negedge clk);
    ns_load_go = 1'b1;
    @(negedge clk);
    ns_load_go = 1'b0;
    cyc = 0;
    while (!ns_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("ns_valid", {639'd0, ns_valid}, 640'd1);
    check("ns_word0", {608'd0, ns_header[639:608]}, 640'hAABBCCDD);
    check("ns_word1", {608'd0, ns_header[607:576]}, 640'h1);
    check("ns_nonce", {608'd0, ns_nonce}, 640'h13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/work_loader.md
# work_loader

Receives the 80-byte Bitcoin block header as a stream of 32-bit words from the PCIe read-master user FIFO, optionally byte-swaps each word, and assembles a complete 640-bit header. It then presents the header to the hashing core through a valid/ready handshake. It sits between the read-master user port (read_master_user_*) and the hashing core, and is sequenced by the user-logic controller through `load_go` and `abort`.

## Interface
Parameters:
- HDR_WORDS, 20: words per header; the word counter is $clog2(HDR_WORDS) bits wide.
- SWAP_BYTES, 1: 1 = reverse byte order of each word on capture; 0 = capture unchanged.

Ports:
- clk  in  1  system clock (soc_clk domain).
- n_rst  in  1  asynchronous, active-low reset.
- load_go  in  1  single-cycle pulse that starts loading one header.
- abort  in  1  synchronous flush to IDLE; priority over every other input.
- read_user_data_available  in  1  FIFO non-empty.
- read_user_buffer_output_data  in  32  FIFO head word (show-ahead).
- read_user_read_buffer  out  1  pop/acknowledge of the FIFO head word.
- header  out  640  assembled header; word 0 at [639:608], word 19 at [31:0].
- nonce_base  out  32  equals header[31:0] (word 19, after swap).
- work_valid  out  1  header complete and stable.
- work_ready  in  1  core accepts the header.
- busy  out  1  high in LOAD and HOLD.
- words_loaded  out  5  number of words captured for the current header.
- overrun  out  1  sticky; set when load_go arrives while busy; cleared by reset or abort.

## Operation
- States: IDLE, LOAD, HOLD.
- IDLE:
  - `load_go` → LOAD; words_loaded ← 0; header ← 0.
- LOAD:
  - read_buffer = data_available (combinational, LOAD only).
  - Each cycle with data_available=1: capture the head word (swapped if SWAP_BYTES) into slot words_loaded, then increment words_loaded.
  - On capture of word HDR_WORDS-1 → HOLD.
  - With data_available=0: wait indefinitely, no pop.
- HOLD:
  - work_valid=1; header and nonce_base held constant.
  - work_valid && work_ready → IDLE; words_loaded is held until the next load_go.
  - No pops occur in HOLD.
- abort (any state): → IDLE next edge; no pop that cycle; header and words_loaded cleared; overrun cleared; work_valid drops.
- load_go while busy is ignored and sets overrun. If abort and load_go are asserted together, abort wins and overrun stays 0.
- Byte swap: {d[7:0], d[15:8], d[23:16], d[31:24]}.

## Timing
- Reset values: state IDLE, header 0, nonce_base 0, work_valid 0, read_user_read_buffer 0, busy 0, words_loaded 0, overrun 0.
- load_go at edge N → busy=1 after edge N. The first pop can occur in cycle N+1.
- Throughput is one word per cycle. With the FIFO continuously non-empty, work_valid rises after edge N+20, 20 cycles after the load_go edge.
- Pops happen only in LOAD, so exactly HDR_WORDS pops occur per header. No extra pop happens at the final word.
- work_ready while work_valid=0 has no effect.
- Handshake completes on the edge where both work_valid and work_ready are 1. work_valid is 0 the following cycle.
- Back-to-back operation: load_go in the same cycle as acceptance counts as busy, sets overrun and is ignored. A new load_go is accepted from the first IDLE cycle.
- Reset mid-LOAD: all state clears asynchronously. Already-popped words are lost, and the controller reissues the read.

## Test plan
- Continuous stream 0x00000001..0x00000014, SWAP_BYTES=1, pulse load_go → exactly 20 pops in 20 consecutive cycles. header[639:608]=0x01000000, nonce_base=0x14000000, work_valid rises 20 cycles after load_go; work_ready=1 → IDLE, words_loaded=20.
- Same stream with data_available dropped for 3 cycles after word 7 → no pops during the gap; header identical to the previous case; work_valid delayed by exactly 3 cycles.
- Hold work_ready=0 for 50 cycles in HOLD → work_valid stays 1, header unchanged, zero pops despite a non-empty FIFO.
- abort after 10 words → next cycle IDLE, words_loaded=0, header=0, no pop in the abort cycle. A following load_go loads a fresh header correctly.
- load_go pulsed during LOAD → overrun=1, load unaffected. Then abort+load_go together → IDLE, overrun=0, state not LOAD.
- Assert n_rst=0 asynchronously mid-LOAD (between edges) → all outputs at reset values immediately. SWAP_BYTES=0 run with 0xAABBCCDD as word 0 → header[639:608]=0xAABBCCDD.
